// File: rtl/boid_frame_writer_pkg.sv
// rtl/boid_frame_writer_pkg.sv - shared video geometry, boid count and frame FSM encodings
package boid_frame_writer_pkg;

    localparam int MAX_BOIDS    = 8;
    localparam int BOID_IDX_W   = 3;
    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
    localparam int ADDR_W       = $clog2(PIXEL_COUNT) + 1;

    // Sprite side length (1..4) and the counter width that covers 0..SPRITE-1
    localparam int SPRITE   = 2;
    localparam int SPRITE_W = 2;

    // Frame sequencer state encodings
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/boid_pixel_addr.sv
// rtl/boid_pixel_addr.sv - combinational pixel coordinate to display RAM address with clipping
module boid_pixel_addr
    import boid_frame_writer_pkg::*;
(
    input  logic [10:0]       px,
    input  logic [9:0]        py,
    output logic              in_bounds,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [10:0] WIDTH_LIM  = 11'(VIDEO_WIDTH);
    localparam logic [9:0]  HEIGHT_LIM = 10'(VIDEO_HEIGHT);

    logic [ADDR_W-1:0] px_ext;
    logic [ADDR_W-1:0] py_ext;

    // py*640 built as (py<<9)+(py<<7) so no multiplier is needed
    always_comb begin
        px_ext    = ADDR_W'(px);
        py_ext    = ADDR_W'(py);
        in_bounds = (px < WIDTH_LIM) && (py < HEIGHT_LIM);
        addr      = (py_ext << 9) + (py_ext << 7) + px_ext;
    end

endmodule

// File: rtl/boid_frame_writer.sv
// rtl/boid_frame_writer.sv - per-frame sequencer that clears the display RAM and draws every boid sprite
module boid_frame_writer
    import boid_frame_writer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_end,
    output logic [BOID_IDX_W-1:0] boid_sel,
    input  logic [9:0]            boid_x,
    input  logic [8:0]            boid_y,
    output logic                  mem_clear,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun
);

    localparam logic [SPRITE_W-1:0]   SPRITE_LAST = SPRITE_W'(SPRITE - 1);
    localparam logic [BOID_IDX_W-1:0] BOID_LAST   = BOID_IDX_W'(MAX_BOIDS - 1);

    logic [2:0]          state;
    logic [9:0]          bx;
    logic [8:0]          by;
    logic [SPRITE_W-1:0] dx;
    logic [SPRITE_W-1:0] dy;
    logic [10:0]         px;
    logic [9:0]          py;
    logic                in_bounds;
    logic [ADDR_W-1:0]   addr;

    // Current sprite pixel; widened so the edge clip can see coordinates past the screen
    always_comb begin
        px = {1'b0, bx} + 11'(dx);
        py = {1'b0, by} + 10'(dy);
    end

    boid_pixel_addr u_pixel_addr (
        .px        (px),
        .py        (py),
        .in_bounds (in_bounds),
        .addr      (addr)
    );

    // Frame sequencer: every output is registered, pulses default low each cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            boid_sel   <= '0;
            bx         <= '0;
            by         <= '0;
            dx         <= '0;
            dy         <= '0;
            mem_clear  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mem_clear  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 1'b0;
            frame_done <= 1'b0;

            // A frame boundary while still drawing means the frame budget was blown
            if (frame_end && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    boid_sel <= '0;
                    if (frame_end) begin
                        state     <= S_CLEAR;
                        mem_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    bx    <= boid_x;
                    by    <= boid_y;
                    dx    <= '0;
                    dy    <= '0;
                    state <= S_DRAW;
                end
                S_DRAW: begin
                    // Clipped pixels still take their cycle so the frame latency is fixed
                    mem_we    <= in_bounds;
                    mem_wdata <= in_bounds;
                    if (in_bounds) begin
                        mem_addr <= addr;
                    end
                    if (dx == SPRITE_LAST) begin
                        dx <= '0;
                        if (dy == SPRITE_LAST) begin
                            dy <= '0;
                            if (boid_sel == BOID_LAST) begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                boid_sel   <= '0;
                            end else begin
                                boid_sel <= boid_sel + 1'b1;
                                state    <= S_FETCH;
                            end
                        end else begin
                            dy <= dy + 1'b1;
                        end
                    end else begin
                        dx <= dx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boid_frame_writer.sv
// tb/tb_boid_frame_writer.sv - scoreboard bench for the boid frame writer
module tb_boid_frame_writer;

    logic        clock;
    logic        reset;
    logic        frame_end;
    logic [2:0]  boid_sel;
    logic [9:0]  boid_x;
    logic [8:0]  boid_y;
    logic        mem_clear;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic        mem_wdata;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    logic [9:0]  pos_x [8];
    logic [8:0]  pos_y [8];

    typedef struct {
        int cyc;
        int addr;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks;
    int  n_errors;

    boid_frame_writer dut (
        .clock      (clock),
        .reset      (reset),
        .frame_end  (frame_end),
        .boid_sel   (boid_sel),
        .boid_x     (boid_x),
        .boid_y     (boid_y),
        .mem_clear  (mem_clear),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // BPU array mux model
    assign boid_x = pos_x[boid_sel];
    assign boid_y = pos_y[boid_sel];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_default_boids();
        for (int i = 0; i < 8; i++) begin
            pos_x[i] = 10'd100;
            pos_y[i] = 9'd100;
        end
    endtask

    // Expected write sequence: boid i pixel p=dy*2+dx appears at cycle 4+5*i+p
    task automatic push_expected();
        wr_t e;
        int  px;
        int  py;
        for (int i = 0; i < 8; i++) begin
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    px = int'(pos_x[i]) + dx;
                    py = int'(pos_y[i]) + dy;
                    if (px < 640 && py < 480) begin
                        e.cyc  = 4 + 5 * i + dy * 2 + dx;
                        e.addr = py * 640 + px;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    // Runs one frame; extra_cyc injects a second frame_end, abort_cyc asserts reset after that cycle
    task automatic run_frame(input int extra_cyc, input int abort_cyc);
        wr_t e;
        push_expected();
        @(negedge clock);
        frame_end = 1'b1;
        for (int cyc = 1; cyc <= 44; cyc++) begin
            @(negedge clock);
            frame_end = (cyc == extra_cyc) ? 1'b1 : 1'b0;
            check_eq("mem_clear", int'(mem_clear), (cyc == 1) ? 1 : 0);
            check_eq("frame_done", int'(frame_done), (cyc == 42) ? 1 : 0);
            check_eq("busy", int'(busy), (cyc >= 1 && cyc <= 41) ? 1 : 0);
            check_eq("wdata", int'(mem_wdata), int'(mem_we));
            if (cyc >= 2 && cyc <= 37 && ((cyc - 2) % 5) == 0) begin
                check_eq("boid_sel", int'(boid_sel), (cyc - 2) / 5);
            end
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_we", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_cyc", cyc, e.cyc);
                    check_eq("wr_addr", int'(mem_addr), e.addr);
                end
            end
            if (cyc == abort_cyc) begin
                reset = 1'b1;
                @(negedge clock);
                check_eq("abort_we", int'(mem_we), 0);
                check_eq("abort_busy", int'(busy), 0);
                check_eq("abort_sel", int'(boid_sel), 0);
                check_eq("abort_overrun", int'(overrun), 0);
                reset = 1'b0;
                exp_q.delete();
                break;
            end
        end
        frame_end = 1'b0;
        check_eq("leftover", exp_q.size(), 0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        frame_end = 1'b1;
        set_default_boids();

        // Reset held with frame_end asserted must not start a frame
        repeat (3) @(negedge clock);
        check_eq("rst_sel", int'(boid_sel), 0);
        check_eq("rst_clear", int'(mem_clear), 0);
        check_eq("rst_we", int'(mem_we), 0);
        check_eq("rst_addr", int'(mem_addr), 0);
        check_eq("rst_wdata", int'(mem_wdata), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(frame_done), 0);
        check_eq("rst_overrun", int'(overrun), 0);
        reset     = 1'b0;
        frame_end = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("post_rst_clear", int'(mem_clear), 0);
            check_eq("post_rst_busy", int'(busy), 0);
        end

        // Two known boids near the origin
        pos_x[0] = 10'd0;  pos_y[0] = 9'd0;
        pos_x[1] = 10'd10; pos_y[1] = 9'd20;
        run_frame(-1, -1);
        check_eq("overrun_clean", int'(overrun), 0);

        // Bottom-right corner clip
        set_default_boids();
        pos_x[0] = 10'd639; pos_y[0] = 9'd479;
        run_frame(-1, -1);

        // Fully off-screen boid
        set_default_boids();
        pos_x[0] = 10'd700; pos_y[0] = 9'd50;
        pos_x[1] = 10'd10;  pos_y[1] = 9'd20;
        run_frame(-1, -1);

        // Stray frame_end mid-frame: same writes, sticky overrun
        run_frame(15, -1);
        check_eq("overrun_set", int'(overrun), 1);
        repeat (3) @(negedge clock);
        check_eq("overrun_sticky", int'(overrun), 1);

        // Reset during boid 3 DRAW, then a clean restart
        run_frame(-1, 19);
        repeat (2) @(negedge clock);
        run_frame(-1, -1);
        check_eq("overrun_after_restart", int'(overrun), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
